// File: rtl/imem_dmem_arbiter_if.sv
// rtl/imem_dmem_arbiter_if.sv - request/response bundle between IF/MEM stages, arbiter and unified memory
interface imem_dmem_arbiter_if;
  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_rvalid_op;
  logic [31:0] instr_rdata_op;
  logic        data_req_ip;
  logic        data_we_ip;
  logic [3:0]  data_be_ip;
  logic [31:0] data_addr_ip;
  logic [31:0] data_wdata_ip;
  logic        data_gnt_op;
  logic        data_rvalid_op;
  logic [31:0] data_rdata_op;
  logic        flush_ip;
  logic        mem_req_op;
  logic        mem_we_op;
  logic [3:0]  mem_be_op;
  logic [31:0] mem_addr_op;
  logic [31:0] mem_wdata_op;
  logic        mem_rvalid_ip;
  logic [31:0] mem_rdata_ip;
  logic        timeout_err_op;

  modport slave (
    input  instr_req_ip, instr_addr_ip, data_req_ip, data_we_ip, data_be_ip,
           data_addr_ip, data_wdata_ip, flush_ip, mem_rvalid_ip, mem_rdata_ip,
    output instr_gnt_op, instr_rvalid_op, instr_rdata_op, data_gnt_op,
           data_rvalid_op, data_rdata_op, mem_req_op, mem_we_op, mem_be_op,
           mem_addr_op, mem_wdata_op, timeout_err_op
  );

  modport master (
    output instr_req_ip, instr_addr_ip, data_req_ip, data_we_ip, data_be_ip,
           data_addr_ip, data_wdata_ip, flush_ip, mem_rvalid_ip, mem_rdata_ip,
    input  instr_gnt_op, instr_rvalid_op, instr_rdata_op, data_gnt_op,
           data_rvalid_op, data_rdata_op, mem_req_op, mem_we_op, mem_be_op,
           mem_addr_op, mem_wdata_op, timeout_err_op
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and load/store
module imem_dmem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  imem_dmem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] streak, streak_next;
  logic [7:0] timer;
  logic       drop, drop_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      streak <= 4'd0;
      drop   <= 1'b0;
      timer  <= 8'd0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
      drop   <= drop_next;
      // Only a BUSY state that persists keeps counting; any entry restarts at zero.
      timer  <= (state_next == state && state != IDLE) ? timer + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_next          = state;
    streak_next         = streak;
    drop_next           = drop;
    bus.instr_gnt_op    = 1'b0;
    bus.instr_rvalid_op = 1'b0;
    bus.instr_rdata_op  = 32'd0;
    bus.data_gnt_op     = 1'b0;
    bus.data_rvalid_op  = 1'b0;
    bus.data_rdata_op   = 32'd0;
    bus.mem_req_op      = 1'b0;
    bus.mem_we_op       = 1'b0;
    bus.mem_be_op       = 4'd0;
    bus.mem_addr_op     = 32'd0;
    bus.mem_wdata_op    = 32'd0;
    bus.timeout_err_op  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.data_req_ip && (!bus.instr_req_ip || streak < STREAK_MAX)) begin
            bus.data_gnt_op  = 1'b1;
            bus.mem_req_op   = 1'b1;
            bus.mem_we_op    = bus.data_we_ip;
            bus.mem_be_op    = bus.data_be_ip;
            bus.mem_addr_op  = bus.data_addr_ip;
            bus.mem_wdata_op = bus.data_wdata_ip;
            state_next       = BUSY_D;
            // The streak only measures how long a waiting fetch has been passed over.
            if (!bus.instr_req_ip)
              streak_next = 4'd0;
            else if (streak != 4'hF)
              streak_next = streak + 4'd1;
          end else if (bus.instr_req_ip) begin
            bus.instr_gnt_op = 1'b1;
            bus.mem_req_op   = 1'b1;
            bus.mem_be_op    = 4'hF;
            bus.mem_addr_op  = bus.instr_addr_ip;
            streak_next      = 4'd0;
            state_next       = BUSY_I;
          end
        end
        BUSY_I: begin
          if (bus.flush_ip)
            drop_next = 1'b1;
          if (bus.mem_rvalid_ip) begin
            if (!(drop || bus.flush_ip)) begin
              bus.instr_rvalid_op = 1'b1;
              bus.instr_rdata_op  = bus.mem_rdata_ip;
            end
            state_next = IDLE;
            drop_next  = 1'b0;
          end else if (timer == TIMER_LAST) begin
            bus.timeout_err_op = 1'b1;
            state_next         = IDLE;
            drop_next          = 1'b0;
          end
        end
        BUSY_D: begin
          if (bus.mem_rvalid_ip) begin
            bus.data_rvalid_op = 1'b1;
            bus.data_rdata_op  = bus.mem_rdata_ip;
            state_next         = IDLE;
            drop_next          = 1'b0;
          end else if (timer == TIMER_LAST) begin
            bus.timeout_err_op = 1'b1;
            state_next         = IDLE;
            drop_next          = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores).
- One transaction is outstanding at a time. Data requests win by default; a streak counter bounds instruction starvation.
- Handles pipeline flush of an in-flight fetch and a response timeout.
- Sits between the fetch/memory-stage request ports and the memory model.

Parameters:
- MAX_DATA_STREAK, 4: max consecutive data grants while instr_req_ip is pending before instr is forced to win; legal range 1..15.
- TIMEOUT, 64: cycles in a BUSY state without mem_rvalid_ip before the transaction is abandoned; legal range 2..255.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr_req_ip  in  1  fetch request (level, held until granted)
- instr_addr_ip  in  32  fetch address
- instr_gnt_op  out  1  fetch request accepted this cycle
- instr_rvalid_op  out  1  fetch data valid
- instr_rdata_op  out  32  fetch data
- data_req_ip  in  1  load/store request (level, held until granted)
- data_we_ip  in  1  1=store
- data_be_ip  in  4  byte enables
- data_addr_ip  in  32  data address
- data_wdata_ip  in  32  store data
- data_gnt_op  out  1  data request accepted this cycle
- data_rvalid_op  out  1  load data valid / store ack
- data_rdata_op  out  32  load data
- flush_ip  in  1  branch flush from decode; kills in-flight fetch response
- mem_req_op  out  1  request to memory, one-cycle pulse
- mem_we_op  out  1  write enable to memory
- mem_be_op  out  4  byte enables to memory
- mem_addr_op  out  32  address to memory
- mem_wdata_op  out  32  write data to memory
- mem_rvalid_ip  in  1  memory response (read data or write ack)
- mem_rdata_ip  in  32  memory read data
- timeout_err_op  out  1  one-cycle pulse on abandoned transaction

Behaviour:
- Reset is synchronous, active-high on clock.
  - All outputs 0, state=IDLE, streak=0, drop=0, timer=0.
  - Reset mid-transaction abandons it. A later stray mem_rvalid_ip is ignored because the state is IDLE.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration (combinational, same cycle):
  - Only data_req_ip: grant data.
  - Only instr_req_ip: grant instr.
  - Both requesting: grant data if streak < MAX_DATA_STREAK, otherwise grant instr.
  - The winner's gnt_op=1 and mem_req_op=1 in that cycle, with mem_* muxed from the winner.
  - For an instr grant: mem_we_op=0, mem_be_op=4'hF, mem_wdata_op=0.
  - When mem_req_op=0, all mem_* fields are 0.
  - Next state is BUSY_I or BUSY_D.
- Streak counter (4 bits):
  - Data grant with instr_req_ip=1: streak+1, saturating.
  - Data grant with instr_req_ip=0: streak=0.
  - Instr grant: streak=0.
- BUSY_x states:
  - timer increments each cycle. No grants issue.
  - mem_rvalid_ip=1: the owner's rvalid_op=1 and rdata_op=mem_rdata_ip in the same cycle (combinational, zero added latency). Next state IDLE.
  - data_rdata_op carries mem_rdata_ip for stores as well; the consumer ignores it.
  - Minimum spacing between grants is 2 cycles (grant, then response), so the next grant comes no earlier than the cycle after the response.
  - rvalid_op/rdata_op are 0 whenever not forwarding.
- Timeout:
  - If timer reaches TIMEOUT-1 with no mem_rvalid_ip: timeout_err_op=1 for one cycle, no rvalid to the owner, next state IDLE, timer=0, drop=0.
  - timer clears on every state entry.
- Flush:
  - flush_ip=1 in BUSY_I sets drop. The response then completes the FSM but instr_rvalid_op stays 0.
  - flush_ip in the same cycle as the BUSY_I response also suppresses that response.
  - drop clears on return to IDLE.
  - flush_ip in IDLE or BUSY_D has no effect. A simultaneous instr grant still proceeds; decode is responsible for deasserting the request.
- Requests dropped before grant are not remembered (no queue).

Test Plan:
- Single fetch: instr_req_ip=1, addr=0x0000_0010; mem_rvalid_ip the cycle after the grant with rdata=0x0013_0313 -> gnt in cycle 0; mem_addr_op=0x10, mem_be_op=4'hF; instr_rvalid_op=1 with data 0x0013_0313 in cycle 1; data ports silent.
- Simultaneous requests, streak=0: store addr=0x100, be=4'b0011, wdata=0xDEAD_BEEF, plus a fetch -> data granted first with mem_we_op=1 and those fields; instr granted in the first IDLE cycle after the ack.
- Starvation bound: data_req_ip held high and instr_req_ip held high, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 instr grant, then data resumes with streak=0.
- Flush in flight: fetch granted, flush_ip pulsed 1 cycle later, response after 3 cycles -> instr_rvalid_op never asserted; state returns to IDLE; the next request is granted normally.
- Timeout: data load granted, mem_rvalid_ip held 0, TIMEOUT=64 -> timeout_err_op pulses once 64 cycles after the grant; no data_rvalid_op; a new request is granted next cycle.
- Reset mid-BUSY_D: assert reset, then mem_rvalid_ip=1 after reset deasserts -> all outputs 0; no rvalid forwarded; streak=0.
